// File: rtl/aes_cipher.sv
// Iterative AES-128/192/256 encryption core, one round per clock from a precomputed key schedule.
// Optional simulation trace of round/state/FSM on every clock: define AES_CIPHER_TRACE_EN.
module aes_cipher #(
    parameter int unsigned Nk = 4,
    parameter int unsigned Nr = Nk + 6
) (
    input  logic                  clks,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [127:0]          plainText,
    input  logic [128*(Nr+1)-1:0] keys,
    output logic [127:0]          encryptedText,
    output logic                  done
);

    localparam int unsigned KEYS_W     = 128 * (Nr + 1);
    localparam logic [3:0]  LAST_ROUND = 4'(Nr - 1);

    typedef enum logic [1:0] {IDLE, ROUNDS, FINAL} fsm_t;

    fsm_t         fsm, fsm_n;
    logic [3:0]   round, round_n;
    logic [127:0] state, state_n;
    logic [127:0] ct_n;
    logic         done_n;
    logic [127:0] round_key [Nr+1];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
        endcase
        return s;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes then ShiftRows; byte i sits at row i%4, column i/4, MSB-first in the vector
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = sbox(s[127 - 8*(r + 4*((c + r) % 4)) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    // Round key 0 occupies the most significant 128 bits of the schedule
    for (genvar k = 0; k <= Nr; k++) begin : g_rk
        assign round_key[k] = keys[KEYS_W - 1 - 128*k -: 128];
    end

    always_ff @(posedge clks or posedge reset) begin
        if (reset) begin
            fsm           <= IDLE;
            round         <= 4'd0;
            state         <= '0;
            encryptedText <= '0;
            done          <= 1'b0;
        end else begin
            fsm           <= fsm_n;
            round         <= round_n;
            state         <= state_n;
            encryptedText <= ct_n;
            done          <= done_n;
        end
    end

    always_comb begin
        fsm_n   = fsm;
        round_n = round;
        state_n = state;
        ct_n    = encryptedText;
        done_n  = 1'b0;
        case (fsm)
            IDLE: begin
                if (enable) begin
                    state_n = plainText ^ round_key[0];
                    round_n = 4'd1;
                    fsm_n   = ROUNDS;
                end
            end
            ROUNDS: begin
                state_n = mix_columns(sub_shift(state)) ^ round_key[round];
                round_n = round + 4'd1;
                if (round == LAST_ROUND) begin
                    fsm_n = FINAL;
                end
            end
            FINAL: begin
                ct_n    = sub_shift(state) ^ round_key[Nr];
                done_n  = 1'b1;
                round_n = 4'd0;
                fsm_n   = IDLE;
            end
            default: fsm_n = IDLE;
        endcase
    end

`ifdef AES_CIPHER_TRACE_EN
    always @(posedge clks) begin
        $display("aes_cipher: round=%0d state=%h fsm=%s", round, state, fsm.name());
    end
`endif

endmodule

// File: tb/tb_aes_cipher.sv
// Bench for aes_cipher: three instances (Nk=4/6/8) against a GF(2^8)-arithmetic AES reference model.
module tb_aes_cipher;

    logic           clks = 1'b0;
    logic           reset;
    logic           en4, en6, en8;
    logic [127:0]   pt4, pt6, pt8;
    logic [1919:0]  ks4, ks6, ks8;
    logic [127:0]   ct4, ct6, ct8;
    logic           done4, done6, done8;
    int             compared   = 0;
    int             mismatched = 0;
    logic [7:0]     sbox_t [256];

    always #5 clks = ~clks;

    aes_cipher #(.Nk(4)) dut4 (.clks(clks), .reset(reset), .enable(en4), .plainText(pt4),
        .keys(ks4[1919 -: 1408]), .encryptedText(ct4), .done(done4));
    aes_cipher #(.Nk(6)) dut6 (.clks(clks), .reset(reset), .enable(en6), .plainText(pt6),
        .keys(ks6[1919 -: 1664]), .encryptedText(ct6), .done(done6));
    aes_cipher #(.Nk(8)) dut8 (.clks(clks), .reset(reset), .enable(en8), .plainText(pt8),
        .keys(ks8), .encryptedText(ct8), .done(done8));

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        logic [7:0] s;
        for (int b = 1; b < 256; b++) begin
            if (gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
        end
        s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    // Key schedule; round key k placed at bits [1919-128k -: 128]
    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
        logic [31:0]   w [60];
        logic [31:0]   t;
        logic [7:0]    rc = 8'h01;
        logic [1919:0] res = '0;
        int            nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int k = 0; k <= nr; k++) res[1919 - 128*k -: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return res;
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] p, input logic [1919:0] ks, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) s[i] = p[127 - 8*i -: 8] ^ ks[1919 - 8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
            s = t;
            if (rnd < nr) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[r + 4*c] = gmul(8'h02, s[r + 4*c]) ^ gmul(8'h03, s[(r + 1) % 4 + 4*c])
                                   ^ s[(r + 2) % 4 + 4*c] ^ s[(r + 3) % 4 + 4*c];
                s = t;
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1919 - 128*rnd - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) o[127 - 8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic tick;
        @(posedge clks);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic set_en(input int which, input logic v);
        case (which)
            4: en4 = v;
            6: en6 = v;
            default: en8 = v;
        endcase
    endtask

    task automatic load(input int which, input logic [127:0] p, input logic [1919:0] ks);
        case (which)
            4: begin pt4 = p; ks4 = ks; end
            6: begin pt6 = p; ks6 = ks; end
            default: begin pt8 = p; ks8 = ks; end
        endcase
    endtask

    function automatic logic get_done(input int which);
        return (which == 4) ? done4 : (which == 6) ? done6 : done8;
    endfunction

    function automatic logic [127:0] get_ct(input int which);
        return (which == 4) ? ct4 : (which == 6) ? ct6 : ct8;
    endfunction

    // Accept on edge 0, expect done only on edge Nr with the expected ciphertext
    task automatic run_block(input int which, input logic [127:0] p, input logic [1919:0] ks,
                             input logic [127:0] expv, input string tag);
        int nr = which + 6;
        load(which, p, ks);
        set_en(which, 1'b1);
        tick;
        set_en(which, 1'b0);
        for (int e = 1; e <= nr; e++) begin
            tick;
            if (e < nr) chk({tag, "_done_busy"}, 128'(get_done(which)), 128'd0);
        end
        chk({tag, "_done"}, 128'(get_done(which)), 128'd1);
        chk({tag, "_ct"}, get_ct(which), expv);
        tick;
        chk({tag, "_done_after"}, 128'(get_done(which)), 128'd0);
    endtask

    logic [127:0]  pt_a, pt_b, c1;
    logic [255:0]  key_r;
    logic [1919:0] ks_c1, ks_r;

    initial begin
        reset = 1'b1;
        en4 = 1'b0; en6 = 1'b0; en8 = 1'b0;
        pt4 = '0; pt6 = '0; pt8 = '0;
        ks4 = '0; ks6 = '0; ks8 = '0;
        for (int x = 0; x < 256; x++) sbox_t[x] = sbox_calc(8'(x));
        tick;
        tick;
        chk("reset_ct4", ct4, 128'd0);
        chk("reset_ct6", ct6, 128'd0);
        chk("reset_ct8", ct8, 128'd0);
        chk("reset_done4", 128'(done4), 128'd0);
        chk("reset_done6", 128'(done6), 128'd0);
        chk("reset_done8", 128'(done8), 128'd0);
        reset = 1'b0;
        tick;

        pt_a  = 128'h00112233445566778899aabbccddeeff;
        c1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        ks_c1 = expand({128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        run_block(4, pt_a, ks_c1, c1, "fips_c1");
        run_block(6, pt_a, expand({192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 6),
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, "fips_c2");
        run_block(8, pt_a, expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8),
                  128'h8ea2b7ca516745bfeafc49904b496089, "fips_c3");

        // Reset in the middle of ROUNDS aborts with no done pulse
        pt_b = {$urandom, $urandom, $urandom, $urandom};
        load(4, pt_b, ks_c1);
        set_en(4, 1'b1);
        tick;
        set_en(4, 1'b0);
        repeat (4) tick;
        reset = 1'b1;
        #1;
        chk("abort_ct4", ct4, 128'd0);
        chk("abort_done4", 128'(done4), 128'd0);
        chk("abort_ct6", ct6, 128'd0);
        tick;
        reset = 1'b0;
        for (int e = 6; e <= 14; e++) begin
            tick;
            chk("abort_no_done", 128'(done4), 128'd0);
        end
        chk("abort_ct_held", ct4, 128'd0);
        run_block(4, pt_a, ks_c1, c1, "after_abort");

        // Requests while busy (edge 3 in ROUNDS, edge 10 in FINAL) are dropped; edge 11 is accepted
        load(4, pt_a, ks_c1);
        set_en(4, 1'b1);
        tick;
        for (int e = 1; e <= 21; e++) begin
            en4 = (e == 3 || e == 10 || e == 11);
            if (en4) pt4 = pt_b;
            tick;
            if (e == 10) begin
                chk("busy_first_done", 128'(done4), 128'd1);
                chk("busy_first_ct", ct4, c1);
            end else if (e == 21) begin
                chk("busy_second_done", 128'(done4), 128'd1);
                chk("busy_second_ct", ct4, cipher(pt_b, ks_c1, 10));
            end else begin
                chk("busy_done_low", 128'(done4), 128'd0);
                if (e > 10) chk("busy_ct_hold", ct4, c1);
            end
        end
        en4 = 1'b0;
        tick;
        chk("busy_done_after", 128'(done4), 128'd0);

        run_block(4, 128'd0, expand(256'd0, 4), 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, "zero_key");

        // enable held high: blocks accepted on edges 0 and 11
        pt_a  = {$urandom, $urandom, $urandom, $urandom};
        pt_b  = {$urandom, $urandom, $urandom, $urandom};
        key_r = {$urandom, $urandom, $urandom, $urandom, 128'd0};
        ks_r  = expand(key_r, 4);
        load(4, pt_a, ks_r);
        en4 = 1'b1;
        tick;
        pt4 = pt_b;
        for (int e = 1; e <= 21; e++) begin
            tick;
            if (e == 10) chk("b2b_first_ct", ct4, cipher(pt_a, ks_r, 10));
            if (e == 11) begin
                chk("b2b_done_gap", 128'(done4), 128'd0);
                en4 = 1'b0;
            end
            if (e == 21) begin
                chk("b2b_second_done", 128'(done4), 128'd1);
                chk("b2b_second_ct", ct4, cipher(pt_b, ks_r, 10));
            end
        end
        tick;

        for (int n = 0; n < 9; n++) begin
            int nk = 4 + 2 * (n % 3);
            pt_a  = {$urandom, $urandom, $urandom, $urandom};
            key_r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            ks_r  = expand(key_r, nk);
            run_block(nk, pt_a, ks_r, cipher(pt_a, ks_r, nk + 6), $sformatf("rand_nk%0d", nk));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
